// File: rtl/line_burst_arbiter_pkg.sv
// rv32i_types: shared line/word types and arbiter enums
package rv32i_types;
  typedef logic [255:0] rv32i_line;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, DONE} lba_state_t;
  typedef enum logic {INST, DATA} lba_owner_t;
  localparam int BEAT_W = 64;
endpackage

// File: rtl/line_burst_arbiter_serdes.sv
// line_serdes: beat counter, write-beat mux and read-line assembly
module line_serdes
  import rv32i_types::*;
#(
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    busy,
  input  logic                    mem_resp,
  input  logic [BEAT_W-1:0]       mem_rdata,
  input  logic [BEAT_W*BEATS-1:0] wdata,
  output logic [BEAT_W-1:0]       mem_wdata,
  output logic                    last_beat,
  output logic [BEAT_W*BEATS-1:0] line
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BEAT_W*BEATS-1:0] line_q, line_d;
  logic fire;
  // beats count only on accepted mem_resp; the incoming beat is merged so the
  // final beat is visible in the same cycle it arrives
  always_comb begin
    fire = busy && mem_resp;
    last_beat = fire && cnt_q == CW'(BEATS - 1);
    cnt_d = start || last_beat ? '0 : fire ? cnt_q + 1'b1 : cnt_q;
    line_d = line_q;
    if (fire) line_d[BEAT_W*cnt_q +: BEAT_W] = mem_rdata;
  end
  assign mem_wdata = wdata[BEAT_W*cnt_q +: BEAT_W];
  assign line = line_d;
  // counter and assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      line_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      line_q <= line_d;
    end
  end
endmodule

// File: rtl/line_burst_arbiter.sv
// line_burst_arbiter: line-granular arbitration of one burst memory port between inst and data requesters
module line_burst_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = 2,
  parameter int BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_read,
  input  logic [31:0]             inst_addr,
  output logic [BEAT_W*BEATS-1:0] inst_rdata,
  output logic                    inst_resp,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [31:0]             data_addr,
  input  logic [BEAT_W*BEATS-1:0] data_wdata,
  output logic [BEAT_W*BEATS-1:0] data_rdata,
  output logic                    data_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31:0]             mem_addr,
  output logic [BEAT_W-1:0]       mem_wdata,
  input  logic [BEAT_W-1:0]       mem_rdata,
  input  logic                    mem_resp
);
  localparam int LW = BEAT_W * BEATS;
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  lba_state_t state_q, state_d;
  lba_owner_t owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  rv32i_word addr_q, addr_d;
  logic [LW-1:0] wdata_q, wdata_d, inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d, line;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic inst_resp_q, inst_resp_d, data_resp_q, data_resp_d;
  logic data_req, starved, grant_inst, busy, start, last_beat;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[4:0], data_addr[4:0]};
  line_serdes #(.BEATS(BEATS)) u_serdes (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata),
    .wdata(wdata_q),
    .mem_wdata(mem_wdata),
    .last_beat(last_beat),
    .line(line)
  );
  // grant in IDLE, finish burst on the last beat, pulse resp from DONE
  always_comb begin
    data_req = data_read || data_write;
    starved = streak_q == SW'(STARVE_LIMIT);
    grant_inst = inst_read && (!data_req || starved);
    busy = state_q inside {INST_RD, DATA_RD, DATA_WR};
    start = state_q == IDLE && (inst_read || data_req);
    state_d = state_q;
    owner_d = owner_q;
    streak_d = streak_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mem_read_d = mem_read_q;
    mem_write_d = mem_write_q;
    inst_resp_d = 1'b0;
    data_resp_d = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (start) begin
      owner_d = grant_inst ? INST : DATA;
      state_d = grant_inst ? INST_RD : data_write ? DATA_WR : DATA_RD;
      addr_d = {grant_inst ? inst_addr[31:5] : data_addr[31:5], 5'b0};
      mem_read_d = grant_inst || !data_write;
      mem_write_d = !grant_inst && data_write;
      wdata_d = !grant_inst && data_write ? data_wdata : wdata_q;
      streak_d = grant_inst || !inst_read ? '0 : starved ? streak_q : streak_q + 1'b1;
    end else if (last_beat) begin
      state_d = DONE;
      mem_read_d = 1'b0;
      mem_write_d = 1'b0;
      inst_resp_d = owner_q == INST;
      data_resp_d = owner_q == DATA;
      inst_rdata_d = state_q == INST_RD ? line : inst_rdata_q;
      data_rdata_d = state_q == DATA_RD ? line : data_rdata_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // all FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= INST;
      streak_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      inst_resp_q <= 1'b0;
      data_resp_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      streak_q <= streak_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      inst_resp_q <= inst_resp_d;
      data_resp_q <= data_resp_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr = addr_q;
  assign inst_resp = inst_resp_q;
  assign data_resp = data_resp_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
endmodule

// File: tb/tb_line_burst_arbiter.sv
// tb_line_burst_arbiter: directed vectors and corner sequences for line_burst_arbiter
module tb_line_burst_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_read = 1'b0, data_read = 1'b0, data_write = 1'b0, mem_resp = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0;
  logic [255:0] data_wdata = '0;
  logic [63:0] mem_rdata = '0;
  logic [255:0] inst_rdata, data_rdata;
  logic inst_resp, data_resp, mem_read, mem_write;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  logic [255:0] exp_ird = '0, exp_drd = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_resp(inst_resp),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_resp(data_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    int kind;
    logic [31:0] addr;
    logic [255:0] wd;
    logic [255:0] rl;
    int gap;
    bit stray;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = mem_read || mem_write;
    end
    if (!ok) chk("strobe_timeout", 0, 1);
  endtask

  // memory model: first beat the cycle after the strobe is seen, then gap idle cycles between beats
  task automatic play(input logic [255:0] rl, input logic [255:0] wd, input int gap, input bit wr, input logic [31:0] ea);
    for (int i = 0; i < 4; i++) begin
      mem_resp = 1'b0;
      for (int g = 0; g < ((i == 0) ? 1 : gap); g++) begin
        if (wr) chk("wdata_hold", mem_wdata, wd[64*i +: 64]);
        @(negedge clk);
      end
      mem_resp = 1'b1;
      mem_rdata = rl[64*i +: 64];
      chk("addr_held", mem_addr, ea);
      chk("strobe_held", mem_read || mem_write, 1);
      if (wr) chk("wdata_beat", mem_wdata, wd[64*i +: 64]);
      @(negedge clk);
    end
    mem_resp = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    bit ok, ir, wr;
    int c0;
    ir = v.kind == 0;
    wr = v.kind >= 2;
    inst_read = ir;
    inst_addr = v.addr;
    data_read = v.kind == 1 || v.kind == 3;
    data_write = wr;
    data_addr = v.addr;
    data_wdata = v.wd;
    c0 = cyc;
    wait_strobe(ok);
    if (!ok) return;
    chk("grant_latency", cyc - c0, 1);
    chk("mem_read", mem_read, !wr);
    chk("mem_write", mem_write, wr);
    chk("mem_addr", mem_addr, v.exp_addr);
    play(v.rl, v.wd, v.gap, wr, v.exp_addr);
    if (v.kind == 0) exp_ird = v.rl;
    if (v.kind == 1) exp_drd = v.rl;
    chk("resp_latency", cyc - c0, 6 + 3 * v.gap);
    chk("inst_resp", inst_resp, ir);
    chk("data_resp", data_resp, !ir);
    chk("done_strobes", {mem_read, mem_write}, 0);
    chk("inst_rdata", inst_rdata, exp_ird);
    chk("data_rdata", data_rdata, exp_drd);
    inst_read = 1'b0;
    data_read = 1'b0;
    data_write = 1'b0;
    mem_resp = v.stray;
    mem_rdata = 64'hBADB_ADBA_DBAD_BADB;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("resp_one_cycle", {inst_resp, data_resp}, 0);
    chk("idle_strobes", {mem_read, mem_write}, 0);
    chk("rdata_kept", {inst_rdata == exp_ird, data_rdata == exp_drd}, 2'b11);
  endtask

  initial begin
    bit ok;
    logic [31:0] ord[6];
    logic [255:0] rl;
    tbl[0] = '{kind: 0, addr: 32'h0000_1234, wd: '0,
               rl: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               gap: 0, stray: 1'b1, exp_addr: 32'h0000_1220};
    tbl[1] = '{kind: 2, addr: 32'h8000_0040,
               wd: {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2, 64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
               rl: '0, gap: 2, stray: 1'b0, exp_addr: 32'h8000_0040};
    tbl[2] = '{kind: 1, addr: 32'hDEAD_BEEF, wd: '0,
               rl: {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000},
               gap: 1, stray: 1'b0, exp_addr: 32'hDEAD_BEE0};
    tbl[3] = '{kind: 3, addr: 32'h0000_007F,
               wd: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
               rl: '0, gap: 0, stray: 1'b0, exp_addr: 32'h0000_0060};
    tbl[4] = '{kind: 1, addr: 32'h1234_5678, wd: '0,
               rl: {64'hCCCC_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hCCCC_0000_0000_0002, 64'hCCCC_0000_0000_0001},
               gap: 0, stray: 1'b1, exp_addr: 32'h1234_5660};
    repeat (2) @(negedge clk);
    chk("rst_strobes", {mem_read, mem_write, inst_resp, data_resp}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {inst_rdata, data_rdata} == 0, 1);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) do_txn(tbl[k]);

    // reset after beat 1 of a data read
    data_read = 1'b1;
    data_addr = 32'h0000_0300;
    wait_strobe(ok);
    mem_resp = 1'b0;
    @(negedge clk);
    mem_resp = 1'b1;
    mem_rdata = 64'h9999_0000_0000_0000;
    @(negedge clk);
    mem_rdata = 64'h9999_0000_0000_0001;
    @(negedge clk);
    mem_resp = 1'b0;
    rst = 1'b1;
    data_read = 1'b0;
    @(negedge clk);
    chk("midrst_strobes", {mem_read, mem_write, data_resp, inst_resp}, 0);
    chk("midrst_rdata", {inst_rdata, data_rdata} == 0, 1);
    chk("midrst_addr", mem_addr, 0);
    rst = 1'b0;
    exp_ird = '0;
    exp_drd = '0;
    @(negedge clk);
    chk("midrst_no_resp", {data_resp, inst_resp, mem_read}, 0);
    // stray beats in IDLE
    mem_resp = 1'b1;
    mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (2) @(negedge clk);
    mem_resp = 1'b0;
    chk("idle_stray", {mem_read, mem_write, inst_resp, data_resp}, 0);
    do_txn(tbl[0]);

    // both requesters held: expect D, D, I, D, D, I
    ord = '{32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h100};
    inst_addr = 32'h0000_0100;
    data_addr = 32'h0000_0200;
    inst_read = 1'b1;
    data_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_strobe(ok);
      if (!ok) break;
      chk("grant_order", mem_addr, ord[k]);
      rl = {4{32'h5000_0000 + 32'(k), 32'h0}};
      play(rl, '0, 0, 1'b0, ord[k]);
      if (ord[k] == 32'h100) exp_ird = rl;
      else exp_drd = rl;
      chk("order_resp", {inst_resp, data_resp}, ord[k] == 32'h100 ? 2'b10 : 2'b01);
      chk("order_rdata", {inst_rdata == exp_ird, data_rdata == exp_drd}, 2'b11);
    end
    inst_read = 1'b0;
    data_read = 1'b0;
    @(negedge clk);
    chk("final_idle", {mem_read, mem_write, inst_resp, data_resp}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
